// File: rtl/flip_discs_pkg.sv
// rtl/flip_discs_pkg.sv - shared reversi encodings, direction deltas and FSM states
//
// Package reversi_pkg
//   CELL_*          2-bit cell encodings (11 is reserved)
//   state_t         commit FSM states
//   dir_dx/dir_dy   signed 4-bit step for direction 0..7 (0 = north, clockwise)
//   cell_idx        linear cell index y*8+x
package reversi_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_BLACK = 2'b01;
  localparam logic [1:0] CELL_WHITE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_WALK,
    ST_DONE
  } state_t;

  function automatic logic signed [3:0] dir_dx(input logic [2:0] d);
    case (d)
      3'd1, 3'd2, 3'd3: dir_dx = 4'sd1;
      3'd5, 3'd6, 3'd7: dir_dx = -4'sd1;
      default:          dir_dx = 4'sd0;
    endcase
  endfunction

  function automatic logic signed [3:0] dir_dy(input logic [2:0] d);
    case (d)
      3'd0, 3'd1, 3'd7: dir_dy = -4'sd1;
      3'd3, 3'd4, 3'd5: dir_dy = 4'sd1;
      default:          dir_dy = 4'sd0;
    endcase
  endfunction

  function automatic logic [5:0] cell_idx(input logic [2:0] x, input logic [2:0] y);
    return {y, x};
  endfunction

endpackage

// File: rtl/flip_discs_if.sv
// rtl/flip_discs_if.sv - move-commit bundle between controller and flip_discs
//
// Signals
//   start, x, y, player_black, valid, end_points, board_in   controller -> flipper
//   board_out, busy, done, illegal, mismatch, flip_count     flipper -> controller
// Modports: master (controller side), slave (flip_discs side)
interface flip_discs_if;
  logic         start;
  logic [2:0]   x;
  logic [2:0]   y;
  logic         player_black;
  logic [7:0]   valid;
  logic [47:0]  end_points;
  logic [127:0] board_in;
  logic [127:0] board_out;
  logic         busy;
  logic         done;
  logic         illegal;
  logic         mismatch;
  logic [5:0]   flip_count;

  modport master (
    output start, x, y, player_black, valid, end_points, board_in,
    input  board_out, busy, done, illegal, mismatch, flip_count
  );

  modport slave (
    input  start, x, y, player_black, valid, end_points, board_in,
    output board_out, busy, done, illegal, mismatch, flip_count
  );
endinterface

// File: rtl/flip_discs_lowest_dir_select.sv
// rtl/flip_discs_lowest_dir_select.sv - priority encoder picking the lowest pending direction
//
// Ports
//   mask  in  8  pending direction bits
//   idx   out 3  index of the lowest set bit (0 when mask is empty)
//   any   out 1  mask has at least one bit set
module lowest_dir_select (
  input  logic [7:0] mask,
  output logic [2:0] idx,
  output logic       any
);

  // Scan downwards so the lowest set bit is the last one to win.
  always_comb begin
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) idx = 3'(i);
    end
  end

  assign any = |mask;

endmodule

// File: rtl/flip_discs.sv
// rtl/flip_discs.sv - commits a checked reversi move, recolouring one cell per clock
//
// Ports
//   clk     in  rising-edge clock
//   resetn  in  synchronous reset, active HIGH despite the name
//   bus     flip_discs_if.slave: move request in, board/result/status out
module flip_discs
  import reversi_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  flip_discs_if.slave bus
);

  state_t            state, state_nx;
  logic [2:0]        px, py, dir;
  logic [1:0]        own;
  logic [7:0]        mask;
  logic [47:0]       eps;
  logic signed [3:0] cx, cy;
  logic [3:0]        step;
  logic [127:0]      board;
  logic              illegal_r, mismatch_r;
  logic [5:0]        flips;

  logic [2:0]        sel;
  logic              sel_any;
  logic              off_board, at_end;
  logic [6:0]        cur_bit, place_bit;
  logic [1:0]        own_in;

  lowest_dir_select u_sel (
    .mask (mask),
    .idx  (sel),
    .any  (sel_any)
  );

  always_comb begin
    // Cursor spans -1..8; both -1 (1111) and 8 (1000, wrapped) have bit 3 set.
    off_board = cx[3] | cy[3];
    at_end    = ({cy[2:0], cx[2:0]} == eps[6*dir +: 6]);
    cur_bit   = {cell_idx(cx[2:0], cy[2:0]), 1'b0};
    place_bit = {cell_idx(bus.x, bus.y), 1'b0};
    own_in    = bus.player_black ? CELL_BLACK : CELL_WHITE;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (bus.start) state_nx = ST_SCAN;
      ST_SCAN: state_nx = sel_any ? ST_WALK : ST_DONE;
      ST_WALK: if (off_board || step[3] || at_end) state_nx = ST_SCAN;
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state      <= ST_IDLE;
      board      <= {64{CELL_EMPTY}};
      illegal_r  <= 1'b0;
      mismatch_r <= 1'b0;
      flips      <= '0;
      px         <= '0;
      py         <= '0;
      dir        <= '0;
      own        <= CELL_EMPTY;
      mask       <= '0;
      eps        <= '0;
      cx         <= '0;
      cy         <= '0;
      step       <= '0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: if (bus.start) begin
          px         <= bus.x;
          py         <= bus.y;
          own        <= own_in;
          mask       <= bus.valid;
          eps        <= bus.end_points;
          illegal_r  <= (bus.valid == 8'd0);
          mismatch_r <= 1'b0;
          flips      <= '0;
          board      <= bus.board_in;
          // Later assignment overrides the placed cell of the copied board.
          if (bus.valid != 8'd0) board[place_bit +: 2] <= own_in;
        end
        ST_SCAN: if (sel_any) begin
          mask[sel] <= 1'b0;
          dir       <= sel;
          cx        <= $signed({1'b0, px}) + dir_dx(sel);
          cy        <= $signed({1'b0, py}) + dir_dy(sel);
          step      <= '0;
        end
        ST_WALK: begin
          if (off_board || step[3]) begin
            mismatch_r <= 1'b1;
          end else if (!at_end) begin
            // Opponent colour is own colour with both bits inverted.
            if (board[cur_bit +: 2] != (own ^ 2'b11)) mismatch_r <= 1'b1;
            board[cur_bit +: 2] <= own;
            flips <= flips + 6'd1;
            cx    <= cx + dir_dx(dir);
            cy    <= cy + dir_dy(dir);
            step  <= step + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.board_out  = board;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.done       = (state == ST_DONE);
  assign bus.illegal    = illegal_r;
  assign bus.mismatch   = mismatch_r;
  assign bus.flip_count = flips;

endmodule

// File: tb/tb_flip_discs.sv
// tb/tb_flip_discs.sv - directed scoreboard bench for flip_discs
module tb_flip_discs;
  import reversi_pkg::*;

  typedef struct {
    logic [127:0] board;
    logic [5:0]   fc;
    logic         ill;
    logic         mis;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  logic resetn;
  int n_vec = 0;
  int n_err = 0;
  exp_t sb[$];
  logic [127:0] last_board = '0;
  int dxs[8] = '{0, 1, 1, 1, 0, -1, -1, -1};
  int dys[8] = '{-1, -1, 0, 1, 1, 1, 0, -1};

  flip_discs_if bus();

  flip_discs dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [127:0] put(input logic [127:0] b, input int x, input int y,
                                       input logic [1:0] c);
    logic [127:0] r;
    r = b;
    r[2*(y*8+x) +: 2] = c;
    return r;
  endfunction

  function automatic logic [47:0] epset(input logic [47:0] ep, input int d, input int x,
                                        input int y);
    logic [47:0] r;
    r = ep;
    r[6*d +: 6] = {3'(y), 3'(x)};
    return r;
  endfunction

  // Reference: walk every valid direction on a copy of the board.
  function automatic exp_t model(input logic [127:0] b, input int x, input int y, input bit pb,
                                 input logic [7:0] v, input logic [47:0] ep);
    exp_t e;
    logic [1:0] ownc, oppc;
    int cx, cy;
    bit stop;
    ownc = pb ? 2'b01 : 2'b10;
    oppc = pb ? 2'b10 : 2'b01;
    e.board = b;
    e.fc = 0;
    e.ill = (v == 8'd0);
    e.mis = 0;
    e.lat = 2;
    if (v != 8'd0) e.board[2*(y*8+x) +: 2] = ownc;
    for (int d = 0; d < 8; d++) begin
      if (v[d]) begin
        e.lat += 2;
        cx = x + dxs[d];
        cy = y + dys[d];
        stop = 0;
        while (!stop) begin
          if (cx < 0 || cx > 7 || cy < 0 || cy > 7) begin
            e.mis = 1;
            stop = 1;
          end else if (cy*8 + cx == int'(ep[6*d +: 6])) begin
            stop = 1;
          end else begin
            if (e.board[2*(cy*8+cx) +: 2] != oppc) e.mis = 1;
            e.board[2*(cy*8+cx) +: 2] = ownc;
            e.fc++;
            e.lat++;
            cx += dxs[d];
            cy += dys[d];
          end
        end
      end
    end
    return e;
  endfunction

  task automatic run_move(input string tag, input logic [127:0] b, input int x, input int y,
                          input bit pb, input logic [7:0] v, input logic [47:0] ep,
                          input int poke);
    exp_t e;
    int cyc;
    sb.push_back(model(b, x, y, pb, v, ep));
    @(negedge clk);
    check({tag, "_busy_idle"}, bus.busy, 1'b0);
    check({tag, "_hold"}, bus.board_out, last_board);
    bus.board_in = b;
    bus.x = 3'(x);
    bus.y = 3'(y);
    bus.player_black = pb;
    bus.valid = v;
    bus.end_points = ep;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    check({tag, "_busy_c1"}, bus.busy, 1'b1);
    while (!bus.done && cyc < 100) begin
      bus.start = (cyc == poke);
      if (cyc == poke) begin
        bus.x = 3'd0;
        bus.y = 3'd0;
        bus.valid = 8'hFF;
        bus.board_in = '1;
        bus.player_black = ~pb;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    e = sb.pop_front();
    check({tag, "_done"}, bus.done, 1'b1);
    check({tag, "_latency"}, cyc, e.lat);
    check({tag, "_board"}, bus.board_out, e.board);
    check({tag, "_flips"}, bus.flip_count, e.fc);
    check({tag, "_illegal"}, bus.illegal, e.ill);
    check({tag, "_mismatch"}, bus.mismatch, e.mis);
    last_board = e.board;
  endtask

  initial begin
    logic [127:0] b_init, b3, b_edge;
    logic [47:0]  ep;

    bus.start = 1'b0;
    bus.x = '0;
    bus.y = '0;
    bus.player_black = 1'b0;
    bus.valid = '0;
    bus.end_points = '0;
    bus.board_in = '0;
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    resetn = 1'b0;
    check("rst_board", bus.board_out, '0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_illegal", bus.illegal, 1'b0);
    check("rst_mismatch", bus.mismatch, 1'b0);
    check("rst_flips", bus.flip_count, 6'd0);

    b_init = '0;
    b_init = put(b_init, 3, 3, CELL_WHITE);
    b_init = put(b_init, 4, 3, CELL_BLACK);
    b_init = put(b_init, 3, 4, CELL_BLACK);
    b_init = put(b_init, 4, 4, CELL_WHITE);

    // Opening move: black at (3,2) capturing south.
    ep = epset('0, 4, 3, 4);
    run_move("open", b_init, 3, 2, 1'b1, 8'h10, ep, -1);
    check("open_fc_const", bus.flip_count, 6'd1);
    check("open_cell33", bus.board_out[2*(3*8+3) +: 2], CELL_BLACK);

    // White, back-to-back in the cycle after done: (3,5) capturing north.
    ep = epset('0, 0, 3, 3);
    run_move("white", b_init, 3, 5, 1'b0, 8'h01, ep, -1);

    // Illegal move leaves the board untouched.
    run_move("illegal", b_init, 2, 2, 1'b1, 8'h00, '0, -1);
    check("illegal_unchanged", bus.board_out, b_init);

    // Three directions with 2, 1, 1 flips; a stray start is pulsed mid-walk.
    b3 = '0;
    b3 = put(b3, 4, 3, CELL_WHITE);
    b3 = put(b3, 5, 3, CELL_WHITE);
    b3 = put(b3, 6, 3, CELL_BLACK);
    b3 = put(b3, 3, 4, CELL_WHITE);
    b3 = put(b3, 3, 5, CELL_BLACK);
    b3 = put(b3, 2, 3, CELL_WHITE);
    b3 = put(b3, 1, 3, CELL_BLACK);
    b3 = put(b3, 0, 0, CELL_WHITE);
    b3 = put(b3, 7, 7, CELL_BLACK);
    ep = epset('0, 2, 6, 3);
    ep = epset(ep, 4, 3, 5);
    ep = epset(ep, 6, 1, 3);
    run_move("three", b3, 3, 3, 1'b1, 8'h54, ep, 3);
    check("three_fc_const", bus.flip_count, 6'd4);

    // Corrupt endpoint: the walk runs off the right edge past (7,0).
    b_edge = '0;
    b_edge = put(b_edge, 6, 0, CELL_WHITE);
    b_edge = put(b_edge, 7, 0, CELL_WHITE);
    b_edge = put(b_edge, 0, 1, CELL_WHITE);
    ep = epset('0, 2, 0, 0);
    run_move("edge", b_edge, 5, 0, 1'b1, 8'h04, ep, -1);
    check("edge_row1", bus.board_out[2*8 +: 2], CELL_WHITE);

    // Reset in the middle of a walk.
    @(negedge clk);
    bus.board_in = b3;
    bus.x = 3'd3;
    bus.y = 3'd3;
    bus.player_black = 1'b1;
    bus.valid = 8'h54;
    bus.end_points = epset(epset(epset('0, 2, 6, 3), 4, 3, 5), 6, 1, 3);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    resetn = 1'b0;
    check("abort_board", bus.board_out, '0);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_done", bus.done, 1'b0);
    check("abort_flips", bus.flip_count, 6'd0);
    check("abort_mismatch", bus.mismatch, 1'b0);
    last_board = '0;
    ep = epset('0, 4, 3, 4);
    run_move("after_rst", b_init, 3, 2, 1'b1, 8'h10, ep, -1);

    @(negedge clk);
    check("final_hold", bus.board_out, last_board);
    check("final_idle", bus.busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/flip_discs.md
# flip_discs

Sequential disc-flipping stage directly downstream of the move checker. It consumes that stage's per-direction `valid` mask and 6-bit end points for a move at (x, y), then commits the move to the board. The commit places the mover's disc and walks each valid direction one cell per clock, recolouring captured discs. The updated board and a flip count are returned to the game controller on a one-cycle `done` pulse.

## Interface
Parameters: none; geometry is fixed at 8×8.

Ports:
- `clk` in 1: system clock, rising edge.
- `resetn` in 1: port name per codebase convention, but **active-high, synchronous**: 1 at a rising edge resets.
- `start` in 1: request to commit a move; sampled only in IDLE.
- `x` in 3: column of the placed disc.
- `y` in 3: row of the placed disc.
- `player_black` in 1: 1 = black moves, 0 = white moves.
- `valid` in 8: bit d = direction d captures; this is the move checker's output.
- `end_points` in 48: `[6d+5:6d]` = `{y[2:0],x[2:0]}` of the bracketing own disc in direction d.
- `board_in` in 128: current board; cell i = y*8+x occupies bits `[2i+1:2i]`.
- `board_out` out 128: working/result board register.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when the commit finishes.
- `illegal` out 1: valid only with `done`; 1 = `valid` was 0, so the board is unchanged.
- `mismatch` out 1: valid only with `done`; 1 = a walked cell was not an opponent disc, or a walk left the board.
- `flip_count` out 6: valid with `done`; number of discs recoloured, excluding the placed disc.

## Operation
- Cell encoding:
  - 2'b00: empty.
  - 2'b01: black.
  - 2'b10: white.
  - 2'b11: reserved.
  - Own colour = player_black ? 01 : 10.
- Directions (dx, dy):
  - 0 = (0,−1)
  - 1 = (+1,−1)
  - 2 = (+1,0)
  - 3 = (+1,+1)
  - 4 = (0,+1)
  - 5 = (−1,+1)
  - 6 = (−1,0)
  - 7 = (−1,−1)
- State IDLE:
  - On `start`: latch x, y, player, `valid` into a mask register, and `end_points`.
  - If mask ≠ 0: `board_out` ← `board_in` with cell (x, y) set to own colour.
  - If mask = 0: `board_out` ← `board_in` and set `illegal`.
  - Clear `flip_count` and `mismatch`; go to SCAN.
- State SCAN:
  - If the mask is empty, go to DONE.
  - Otherwise select the lowest set bit d and clear it.
  - Cursor ← (x+dx, y+dy), computed with 4-bit signed arithmetic; go to WALK.
- State WALK:
  - If the cursor is off-board (any coordinate <0 or >7), or the step counter exceeds 7: set `mismatch`, go to SCAN.
  - Else if cursor == end_points[d]: go to SCAN; the endpoint cell is not written.
  - Else:
    - Set `mismatch` if the cell ≠ opponent colour.
    - Write own colour to the cell.
    - `flip_count` += 1.
    - Cursor += (dx, dy); stay in WALK.
- State DONE: `done`=1 for this one cycle; go to IDLE.
- `start` while busy: ignored, with no queueing.
- Reset mid-walk: abort immediately and return to IDLE. No partial result is signalled.

## Timing
- Reset values:
  - State IDLE.
  - `board_out`=0 (all empty).
  - `busy`=0, `done`=0, `illegal`=0, `mismatch`=0, `flip_count`=0.
- Latency: with `start` sampled in cycle 0, `done` is high in cycle 2 + Σ over valid d of (k_d + 2), where k_d = discs flipped in direction d.
- Illegal move: `done` in cycle 2.
- `board_out` changes during WALK. It is final and stable from the `done` cycle until the next accepted `start`.
- `busy` rises in cycle 1 and falls in the cycle after `done`.
- Back-to-back: `start` is accepted in the cycle immediately after `done`.

## Structure
- Package `reversi_pkg`:
  - Cell encodings `CELL_EMPTY`, `CELL_BLACK`, `CELL_WHITE`.
  - Direction delta constants/function `dir_dx(d)`, `dir_dy(d)`.
  - Cell index function `cell_idx(x,y)`.
  - FSM state typedef.
- Sub-module `lowest_dir_select`: combinational 8-bit priority encoder giving index plus any-set flag, used by SCAN. All else is inline in `flip_discs`.

## Test plan
- Initial position (d4=W, e4=B, d5=B, e5=W); black plays (3,2) with valid=8'h10 and endpoint dir4={3'd4,3'd3} → cell (3,3) becomes black, flip_count=1, mismatch=0, done in cycle 5.
- Three valid directions with 2, 1 and 1 flips → flip_count=4, done in cycle 2+4+3+3=12; only the walked cells change.
- valid=0 → done in cycle 2, illegal=1, board_out==board_in, flip_count=0.
- Corrupt endpoint so the walk runs off the edge from (7,0) in dir 2 → mismatch=1, done still asserted, no write past the column.
- Assert resetn in the middle of a walk, then issue a new start → outputs return to reset values; the next commit completes correctly from the fresh board_in.
- Pulse start while busy → ignored; flip_count and board_out match the first move only; start in the cycle after done → accepted.
